// File: rtl/ne_window_detector.sv
// Sums nonlinear-energy samples over fixed 2**WIN_LOG2-sample windows, compares each
// window sum to a runtime threshold and flags CONSEC_N consecutive above-threshold windows.
module ne_window_detector #(
    parameter  int DATA_WIDTH = 32,
    parameter  int WIN_LOG2   = 8,
    parameter  int CONSEC_N   = 3,
    localparam int SUM_W      = DATA_WIDTH + 1 + WIN_LOG2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_WIDTH:0] din,
    input  logic                din_valid,
    input  logic                clear,
    input  logic [SUM_W-1:0]    thresh,
    output logic [SUM_W-1:0]    win_sum,
    output logic                win_valid,
    output logic                above,
    output logic                detect
);

    localparam int CNT_W = $clog2(CONSEC_N + 1);

    typedef enum logic {
        ST_IDLE,
        ST_DETECT
    } state_e;

    state_e              state_q,     state_d;
    logic [SUM_W-1:0]    acc_q,       acc_d;
    logic [WIN_LOG2-1:0] samp_cnt_q,  samp_cnt_d;
    logic [CNT_W-1:0]    run_cnt_q,   run_cnt_d;
    logic [SUM_W-1:0]    win_sum_q,   win_sum_d;
    logic                win_valid_q, win_valid_d;
    logic                above_q,     above_d;

    logic [SUM_W-1:0]    din_ext;
    logic [SUM_W-1:0]    win_total;
    logic                win_above;
    logic                last_samp;
    logic [CNT_W-1:0]    run_inc;

    // SUM_W is exact for a full window, so plain wrap-free addition suffices.
    assign din_ext   = {{WIN_LOG2{din[DATA_WIDTH]}}, din};
    assign win_total = acc_q + din_ext;
    assign win_above = $signed(win_total) > $signed(thresh);
    assign last_samp = &samp_cnt_q;
    assign run_inc   = (run_cnt_q == CNT_W'(CONSEC_N)) ? run_cnt_q : run_cnt_q + CNT_W'(1);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d     = state_q;
        acc_d       = acc_q;
        samp_cnt_d  = samp_cnt_q;
        run_cnt_d   = run_cnt_q;
        win_sum_d   = win_sum_q;
        win_valid_d = 1'b0;
        above_d     = above_q;

        if (clear) begin
            state_d    = ST_IDLE;
            acc_d      = '0;
            samp_cnt_d = '0;
            run_cnt_d  = '0;
            above_d    = 1'b0;
        end else if (din_valid) begin
            if (!last_samp) begin
                acc_d      = win_total;
                samp_cnt_d = samp_cnt_q + WIN_LOG2'(1);
            end else begin
                acc_d       = '0;
                samp_cnt_d  = '0;
                win_sum_d   = win_total;
                above_d     = win_above;
                win_valid_d = 1'b1;

                // Detector only advances when a window closes.
                unique case (state_q)
                    ST_IDLE: begin
                        if (win_above) begin
                            run_cnt_d = run_inc;
                            if (run_inc == CNT_W'(CONSEC_N)) state_d = ST_DETECT;
                        end else begin
                            run_cnt_d = '0;
                        end
                    end
                    ST_DETECT: begin
                        if (!win_above) begin
                            run_cnt_d = '0;
                            state_d   = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            samp_cnt_q  <= '0;
            run_cnt_q   <= '0;
            win_sum_q   <= '0;
            win_valid_q <= 1'b0;
            above_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            samp_cnt_q  <= samp_cnt_d;
            run_cnt_q   <= run_cnt_d;
            win_sum_q   <= win_sum_d;
            win_valid_q <= win_valid_d;
            above_q     <= above_d;
        end
    end

    assign win_sum   = win_sum_q;
    assign win_valid = win_valid_q;
    assign above     = above_q;
    assign detect    = (state_q == ST_DETECT);

endmodule

// File: tb/tb_ne_window_detector.sv
// Self-checking bench for ne_window_detector: behavioural model feeds a scoreboard
// queue on every closing sample; a negedge monitor pops and compares window results.
module tb_ne_window_detector;

    localparam int DW      = 32;
    localparam int WL      = 2;
    localparam int WIN_LEN = 1 << WL;
    localparam int N       = 3;
    localparam int SW      = DW + 1 + WL;
    localparam int WLB     = 8;
    localparam int SWB     = DW + 1 + WLB;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW:0]   din = '0;
    logic          din_valid = 1'b0;
    logic          clear = 1'b0;
    logic [SW-1:0] thresh = '0;
    logic [SW-1:0] win_sum;
    logic          win_valid, above, detect;

    logic [DW:0]    b_din = '0;
    logic           b_valid = 1'b0;
    logic           b_clear = 1'b0;
    logic [SWB-1:0] b_thresh = '0;
    logic [SWB-1:0] b_win_sum;
    logic           b_win_valid, b_above, b_detect;

    ne_window_detector #(.DATA_WIDTH(DW), .WIN_LOG2(WL), .CONSEC_N(N)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
        .thresh(thresh), .win_sum(win_sum), .win_valid(win_valid), .above(above),
        .detect(detect)
    );

    ne_window_detector #(.DATA_WIDTH(DW), .WIN_LOG2(WLB), .CONSEC_N(N)) dut_big (
        .clk(clk), .rst(rst), .din(b_din), .din_valid(b_valid), .clear(b_clear),
        .thresh(b_thresh), .win_sum(b_win_sum), .win_valid(b_win_valid), .above(b_above),
        .detect(b_detect)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        longint sum;
        bit     above;
        bit     det;
        int     cyc;
    } exp_t;

    exp_t sb[$];

    longint m_acc = 0, m_last = 0, m_thresh = 0;
    int     m_cnt = 0, m_run = 0;
    bit     m_det = 0, m_above = 0;

    task automatic model_reset(input bit full);
        m_acc = 0; m_cnt = 0; m_run = 0; m_det = 0; m_above = 0;
        if (full) m_last = 0;
    endtask

    task automatic set_thresh(input longint t);
        m_thresh = t;
        thresh   = SW'(t);
    endtask

    // Drive one valid sample; model predicts the window result if this sample closes it.
    task automatic send(input longint d);
        din       = (DW+1)'(d);
        din_valid = 1'b1;
        m_acc += d;
        m_cnt++;
        if (m_cnt == WIN_LEN) begin
            m_last  = m_acc;
            m_above = (m_acc > m_thresh);
            if (m_above) begin
                if (m_run < N) m_run++;
            end else begin
                m_run = 0;
            end
            m_det = (m_run == N);
            sb.push_back('{m_acc, m_above, m_det, cyc + 1});
            m_acc = 0;
            m_cnt = 0;
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_clear();
        clear     = 1'b1;
        din_valid = 1'b1;
        din       = (DW+1)'(999);
        @(posedge clk); #1;
        clear     = 1'b0;
        din_valid = 1'b0;
        model_reset(1'b0);
        check("clr_win_valid", longint'(win_valid), 0);
        check("clr_above", longint'(above), 0);
        check("clr_detect", longint'(detect), 0);
        check("clr_win_sum_hold", longint'($signed(win_sum)), m_last);
    endtask

    always @(negedge clk) begin
        if (rst && win_valid) begin
            if (sb.size() == 0) begin
                check("spurious_win_valid", longint'(win_valid), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_win_sum", longint'($signed(win_sum)), e.sum);
                check("sb_above", longint'(above), longint'(e.above));
                check("sb_detect", longint'(detect), longint'(e.det));
                check("sb_latency", longint'(cyc), longint'(e.cyc));
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_win_sum", longint'(win_sum), 0);
        check("rst_win_valid", longint'(win_valid), 0);
        check("rst_above", longint'(above), 0);
        check("rst_detect", longint'(detect), 0);
        rst = 1'b1;
        idle(1);

        // Contiguous window 10,20,30,40 above thresh 50
        set_thresh(50);
        send(10); send(20); send(30); send(40);
        check("t2_win_sum", longint'($signed(win_sum)), 100);
        check("t2_above", longint'(above), 1);
        check("t2_detect", longint'(detect), 0);
        idle(2);
        check("t2_valid_pulse_drop", longint'(win_valid), 0);
        check("t2_sum_hold", longint'($signed(win_sum)), 100);

        // Negative samples below thresh 0
        set_thresh(0);
        send(-5); send(-5); send(-5); send(-5);
        check("t3_win_sum", longint'($signed(win_sum)), -20);
        check("t3_above", longint'(above), 0);
        idle(1);

        // Same window with gaps between samples
        set_thresh(50);
        send(10); idle(2); send(20); idle(2); send(30); idle(2); send(40);
        check("t4_win_sum", longint'($signed(win_sum)), 100);
        check("t4_above", longint'(above), 1);
        idle(3);

        // Detector: three above windows back to back, then a zero window
        do_clear();
        for (int w = 0; w < 3; w++) begin
            send(10); send(20); send(30); send(40);
            if (w < 2) check("t5_detect_low", longint'(detect), 0);
        end
        check("t5_detect_rise", longint'(detect), 1);
        send(0); send(0); send(0); send(0);
        check("t5_detect_fall", longint'(detect), 0);
        check("t5_zero_sum", longint'($signed(win_sum)), 0);

        // Re-arm detect, then async reset mid-window
        for (int w = 0; w < 3; w++) begin
            send(25); send(25); send(25); send(25);
        end
        check("t1_detect_before", longint'(detect), 1);
        send(7); send(7);
        #2;
        rst = 1'b0;
        #1;
        model_reset(1'b1);
        check("t1_async_win_sum", longint'(win_sum), 0);
        check("t1_async_above", longint'(above), 0);
        check("t1_async_detect", longint'(detect), 0);
        check("t1_async_valid", longint'(win_valid), 0);
        @(posedge clk); @(posedge clk); #1;
        check("t1_hold_win_sum", longint'(win_sum), 0);
        check("t1_hold_detect", longint'(detect), 0);
        rst = 1'b1;
        idle(1);
        set_thresh(5);
        send(1); send(2); send(3); send(4);
        check("t1_post_rst_sum", longint'($signed(win_sum)), 10);
        idle(1);

        // Clear with a valid sample in the same cycle discards partial window and sample
        set_thresh(50);
        send(100); send(200);
        do_clear();
        send(1); send(1); send(1); send(1);
        check("t6_win_sum", longint'($signed(win_sum)), 4);
        check("t6_detect", longint'(detect), 0);
        idle(2);

        // Wide window of max-positive samples: no overflow
        b_thresh = '0;
        b_din    = {1'b0, {DW{1'b1}}};
        b_valid  = 1'b1;
        for (int i = 0; i < (1 << WLB); i++) begin
            @(posedge clk); #1;
            if (i == (1 << WLB) - 2) check("big_no_early_valid", longint'(b_win_valid), 0);
        end
        b_valid = 1'b0;
        check("big_win_valid", longint'(b_win_valid), 1);
        check("big_win_sum", longint'($signed(b_win_sum)), longint'(1 << WLB) * 64'd4294967295);
        check("big_above", longint'(b_above), 1);
        check("big_detect", longint'(b_detect), 0);
        idle(3);

        check("sb_drain", longint'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
